// File: rtl/filter_ctrl_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : filter_ctrl_sequencer_pkg
//  Description : Shared types and helpers for the trapezoidal-filter run-time
//                controller: FSM state encoding, coefficient-set struct,
//                power-up coefficient defaults, legality and warm-up helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package filter_ctrl_sequencer_pkg;

    localparam int COEF_K_W = 6;   // width of k and l
    localparam int COEF_M_W = 8;   // width of m1 and m2

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    typedef struct packed {
        logic [COEF_K_W-1:0] k;
        logic [COEF_K_W-1:0] l;
        logic [COEF_M_W-1:0] m1;
        logic [COEF_M_W-1:0] m2;
    } coef_t;

    localparam coef_t COEF_DEFAULT = '{k: 6'd8, l: 6'd4, m1: 8'd1, m2: 8'd16};

    // A set is usable only if k is non-zero and the longest tap (k+l+1)
    // still fits in the delay line. Four guard bits keep the sum exact.
    function automatic logic coef_legal(input coef_t c, input int unsigned depth);
        logic [COEF_K_W+3:0] span;
        span = {4'b0, c.k} + {4'b0, c.l} + (COEF_K_W+4)'(1);
        return (c.k != '0) && (32'(span) <= depth);
    endfunction

    // Warm-up window: delay lines must be refilled (k+l+1) plus the fixed
    // filter register latency before the output reflects only the new set.
    function automatic logic [COEF_K_W+3:0] settle_window(input coef_t c,
                                                          input int unsigned pipe_lat);
        return {4'b0, c.k} + {4'b0, c.l} + (COEF_K_W+4)'(1) + (COEF_K_W+4)'(pipe_lat);
    endfunction

endpackage : filter_ctrl_sequencer_pkg
`default_nettype wire

// File: rtl/filter_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : filter_ctrl_sequencer
//  Description : Run-time controller for one trapezoidal shaping filter.
//                Accepts coefficient sets (valid/ready), range-checks them,
//                and applies a new set only through a flush (filter reset for
//                RST_CYC cycles, then a settle window of k+l+1+PIPE_LAT
//                cycles) before qualifying the filter output with out_valid.
//  Ports       : clk, reset (async, active-low)
//                run                  - 1 = operate, 0 = hold filter in reset
//                cfg_valid/cfg_ready  - coefficient-set handshake
//                cfg_k/l/m1/m2        - offered set
//                cfg_err              - 1-cycle pulse, offered set rejected
//                filt_rst_n           - active-low filter reset
//                filt_k/l/m1/m2       - active set driven to the filter
//                out_valid            - filter output meaningful
//                state_o              - IDLE=0 FLUSH=1 SETTLE=2 RUN=3
//                restart_cnt          - saturating flush counter
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_ctrl_sequencer
    import filter_ctrl_sequencer_pkg::*;
#(
    parameter int K_W      = COEF_K_W,
    parameter int M_W      = COEF_M_W,
    parameter int DEPTH    = 40,
    parameter int RST_CYC  = 4,
    parameter int PIPE_LAT = 6,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [K_W-1:0]   cfg_k,
    input  logic [K_W-1:0]   cfg_l,
    input  logic [M_W-1:0]   cfg_m1,
    input  logic [M_W-1:0]   cfg_m2,
    output logic             cfg_err,
    output logic             filt_rst_n,
    output logic [K_W-1:0]   filt_k,
    output logic [K_W-1:0]   filt_l,
    output logic [M_W-1:0]   filt_m1,
    output logic [M_W-1:0]   filt_m2,
    output logic             out_valid,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] restart_cnt
);

    localparam int c_win_w = K_W + 4;
    // The shared down-counter must hold both the reset hold and the window.
    localparam int c_tmr_w = (c_win_w > $clog2(RST_CYC + 1)) ? c_win_w : $clog2(RST_CYC + 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_tmr_w-1:0]   r_tmr;
    logic [c_tmr_w-1:0]   w_tmr_nxt;
    coef_t                r_shadow;
    coef_t                r_active;
    coef_t                w_cfg;
    coef_t                w_shadow_nxt;
    logic                 w_accept;
    logic                 w_legal;
    logic                 w_take;
    logic                 w_flush_entry;
    logic [c_win_w-1:0]   w_window;
    logic                 r_out_valid;
    logic                 r_cfg_err;
    logic [CNT_W-1:0]     r_restart;

    assign w_cfg        = '{k: cfg_k, l: cfg_l, m1: cfg_m1, m2: cfg_m2};
    // The shadow set must stay frozen while the filter is being flushed.
    assign cfg_ready    = (r_state != ST_FLUSH);
    assign w_accept     = cfg_valid & cfg_ready;
    assign w_legal      = coef_legal(w_cfg, DEPTH);
    assign w_take       = w_accept & w_legal;
    // A set taken on the same edge as a flush entry goes straight to filt_*.
    assign w_shadow_nxt = w_take ? w_cfg : r_shadow;
    assign w_window     = settle_window(r_active, PIPE_LAT);

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_nxt     = r_tmr;
        w_flush_entry = 1'b0;
        if (!run) begin
            // Dropping run wins over everything, including a new set.
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_flush_entry = 1'b1;
                end
                ST_FLUSH: begin
                    if (r_tmr == '0) begin
                        w_state_nxt = ST_SETTLE;
                        w_tmr_nxt   = c_tmr_w'(w_window - c_win_w'(1));
                    end else begin
                        w_tmr_nxt = r_tmr - c_tmr_w'(1);
                    end
                end
                ST_SETTLE: begin
                    if (w_take) begin
                        w_flush_entry = 1'b1;
                    end else if (r_tmr == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_tmr_nxt = r_tmr - c_tmr_w'(1);
                    end
                end
                ST_RUN: begin
                    if (w_take) begin
                        w_flush_entry = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
        if (w_flush_entry) begin
            w_state_nxt = ST_FLUSH;
            w_tmr_nxt   = c_tmr_w'(RST_CYC - 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient registers and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow    <= COEF_DEFAULT;
            r_active    <= COEF_DEFAULT;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_restart   <= '0;
        end else begin
            r_shadow    <= w_shadow_nxt;
            r_cfg_err   <= w_accept & ~w_legal;
            r_out_valid <= (w_state_nxt == ST_RUN);
            if (w_flush_entry) begin
                r_active <= w_shadow_nxt;
                if (r_restart != '1) begin
                    r_restart <= r_restart + CNT_W'(1);
                end
            end else if ((r_state == ST_IDLE) && w_take) begin
                // Filter is held in reset anyway, so load immediately.
                r_active <= w_cfg;
            end
        end
    end

    assign filt_rst_n  = (r_state == ST_SETTLE) || (r_state == ST_RUN);
    assign filt_k      = r_active.k;
    assign filt_l      = r_active.l;
    assign filt_m1     = r_active.m1;
    assign filt_m2     = r_active.m2;
    assign out_valid   = r_out_valid;
    assign cfg_err     = r_cfg_err;
    assign state_o     = r_state;
    assign restart_cnt = r_restart;

endmodule : filter_ctrl_sequencer
`default_nettype wire

// File: tb/tb_filter_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_ctrl_sequencer
//  Description : Self-checking bench for filter_ctrl_sequencer. Directed
//                scenarios followed by randomized traffic, all compared
//                against a timeline-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_ctrl_sequencer;

    localparam int K_W      = 6;
    localparam int M_W      = 8;
    localparam int DEPTH    = 40;
    localparam int RST_CYC  = 4;
    localparam int PIPE_LAT = 6;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [K_W-1:0]   cfg_k = '0;
    logic [K_W-1:0]   cfg_l = '0;
    logic [M_W-1:0]   cfg_m1 = '0;
    logic [M_W-1:0]   cfg_m2 = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             filt_rst_n;
    logic [K_W-1:0]   filt_k;
    logic [K_W-1:0]   filt_l;
    logic [M_W-1:0]   filt_m1;
    logic [M_W-1:0]   filt_m2;
    logic             out_valid;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] restart_cnt;

    filter_ctrl_sequencer #(
        .K_W(K_W), .M_W(M_W), .DEPTH(DEPTH), .RST_CYC(RST_CYC),
        .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m1(cfg_m1), .cfg_m2(cfg_m2),
        .cfg_err(cfg_err), .filt_rst_n(filt_rst_n),
        .filt_k(filt_k), .filt_l(filt_l), .filt_m1(filt_m1), .filt_m2(filt_m2),
        .out_valid(out_valid), .state_o(state_o), .restart_cnt(restart_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the active flush is described by the cycle it began
    // and its settle window; the phase follows from elapsed time.
    int m_cyc;
    int m_tflush;
    int m_w;
    int m_rc;
    bit m_idle;
    bit m_err;
    int m_act[4];
    int m_sh[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (m_idle)                                return 0;
        if (m_cyc < m_tflush + RST_CYC)            return 1;
        if (m_cyc < m_tflush + RST_CYC + m_w)      return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_err = 1'b0; m_rc = 0; m_cyc = 0; m_tflush = 0; m_w = 0;
        m_act = '{8, 4, 1, 16};
        m_sh  = '{8, 4, 1, 16};
    endtask

    // Called right after a rising edge with the inputs that edge sampled.
    task automatic model_step();
        int s;
        bit acc;
        bit leg;
        int cfg[4];
        s   = exp_state();
        cfg = '{int'(cfg_k), int'(cfg_l), int'(cfg_m1), int'(cfg_m2)};
        acc = cfg_valid && (s != 1);
        leg = (cfg[0] >= 1) && (cfg[0] + cfg[1] + 1 <= DEPTH);
        m_err = acc && !leg;
        if (acc && leg) m_sh = cfg;
        m_cyc++;
        if (!run) begin
            if (s == 0 && acc && leg) m_act = cfg;
            m_idle = 1'b1;
        end else if (s == 0 || (acc && leg && s >= 2)) begin
            m_act    = m_sh;
            m_w      = m_act[0] + m_act[1] + 1 + PIPE_LAT;
            m_tflush = m_cyc;
            m_idle   = 1'b0;
            if (m_rc < (1 << CNT_W) - 1) m_rc++;
        end
    endtask

    task automatic check_all();
        int s;
        s = exp_state();
        check("state",       32'(state_o),     32'(s));
        check("filt_rst_n",  32'(filt_rst_n),  32'(s >= 2));
        check("out_valid",   32'(out_valid),   32'(s == 3));
        check("cfg_ready",   32'(cfg_ready),   32'(s != 1));
        check("cfg_err",     32'(cfg_err),     32'(m_err));
        check("filt_k",      32'(filt_k),      32'(m_act[0]));
        check("filt_l",      32'(filt_l),      32'(m_act[1]));
        check("filt_m1",     32'(filt_m1),     32'(m_act[2]));
        check("filt_m2",     32'(filt_m2),     32'(m_act[3]));
        check("restart_cnt", 32'(restart_cnt), 32'(m_rc));
    endtask

    // One clock: drive at the falling edge, model at the rising edge,
    // compare at the next falling edge.
    task automatic drive(input bit r, input bit v, input int k, input int l,
                         input int m1, input int m2);
        run = r; cfg_valid = v;
        cfg_k = K_W'(k); cfg_l = K_W'(l); cfg_m1 = M_W'(m1); cfg_m2 = M_W'(m2);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic step(input bit r);
        drive(r, 1'b0, int'(cfg_k), int'(cfg_l), int'(cfg_m1), int'(cfg_m2));
    endtask

    initial begin
        int n;
        int k;
        int l;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        reset = 1'b1;
        check_all();

        // Defaults: out_valid 1+4+19 cycles after run rises.
        n = 0;
        do begin step(1'b1); n++; end while (!out_valid && n < 100);
        check("lat_default", 32'(n), 32'd24);
        check("restart_1", 32'(restart_cnt), 32'd1);

        // New legal set in RUN: immediate flush with the new coefficients.
        drive(1'b1, 1'b1, 10, 5, 2, 8);
        check("new_set_state", 32'(state_o), 32'd1);
        check("new_set_k", 32'(filt_k), 32'd10);
        n = 1;
        while (!out_valid && n < 100) begin step(1'b1); n++; end
        check("lat_new_set", 32'(n), 32'd27);
        check("restart_2", 32'(restart_cnt), 32'd2);

        // Illegal sets: error pulse, nothing else moves.
        drive(1'b1, 1'b1, 0, 3, 5, 5);
        check("err_k0", 32'(cfg_err), 32'd1);
        step(1'b1);
        check("err_pulse_end", 32'(cfg_err), 32'd0);
        drive(1'b1, 1'b1, 30, 10, 5, 5);
        check("err_span41", 32'(cfg_err), 32'd1);
        check("err_keeps_valid", 32'(out_valid), 32'd1);
        check("err_keeps_k", 32'(filt_k), 32'd10);
        // Exactly k+l+1 = DEPTH is legal.
        drive(1'b1, 1'b1, 29, 10, 3, 3);
        check("edge_legal_state", 32'(state_o), 32'd1);

        // Offers held through FLUSH are ignored, then taken in SETTLE.
        n = 0;
        while (exp_state() == 1 && n < 50) begin
            drive(1'b1, 1'b1, 12, 6, 4, 4); n++;
            check("flush_holds_k", 32'(filt_k), 32'd29);
        end
        drive(1'b1, 1'b1, 12, 6, 4, 4);
        check("settle_restart", 32'(state_o), 32'd1);
        check("settle_restart_k", 32'(filt_k), 32'd12);

        // run=0 together with a legal set in RUN: IDLE wins, set kept.
        n = 0;
        while (exp_state() != 3 && n < 200) begin step(1'b1); n++; end
        drive(1'b0, 1'b1, 7, 7, 9, 9);
        check("runoff_state", 32'(state_o), 32'd0);
        check("runoff_valid", 32'(out_valid), 32'd0);
        check("runoff_keeps_k", 32'(filt_k), 32'd12);
        step(1'b0);
        n = 0;
        do begin step(1'b1); n++; end while (!out_valid && n < 100);
        check("lat_shadow_set", 32'(n), 32'd26);
        check("shadow_applied_k", 32'(filt_k), 32'd7);

        // Asynchronous reset in the middle of SETTLE.
        drive(1'b1, 1'b1, 3, 3, 1, 1);
        n = 0;
        while (exp_state() != 2 && n < 20) begin step(1'b1); n++; end
        #2 reset = 1'b0;
        #1;
        check("arst_state", 32'(state_o), 32'd0);
        check("arst_rst_n", 32'(filt_rst_n), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_restart", 32'(restart_cnt), 32'd0);
        check("arst_k", 32'(filt_k), 32'd8);
        model_reset();
        cfg_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_all();
        step(1'b1);
        check("post_arst_k", 32'(filt_k), 32'd8);

        // Randomized traffic, biased toward the legality boundary.
        for (int i = 0; i < 3000; i++) begin
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 1 && k <= 39) l = 39 - k + int'($urandom_range(0, 1));
            else                                      l = int'($urandom_range(0, 63));
            drive($urandom_range(0, 59) != 0, $urandom_range(0, 19) == 0, k, l,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        // Enough run toggles to pin the restart counter at all-ones.
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            step(1'b1);
        end
        check("restart_sat", 32'(restart_cnt), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_filter_ctrl_sequencer
`default_nettype wire
